mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over a req/ack data-memory handshake,
// registered writeback latch, load-hazard publication and an access watchdog.
module mem_stage #(
  parameter int DBITS   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic             in_wr_reg,
  input  logic [4:0]       in_reg_dest,
  input  logic [DBITS-1:0] in_result,
  input  logic [DBITS-1:0] in_mem_addr,
  input  logic [DBITS-1:0] in_pc,
  output logic             in_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DBITS-1:0] dmem_addr,
  output logic [DBITS-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DBITS-1:0] dmem_rdata,
  output logic             out_valid,
  output logic             out_wr_reg,
  output logic [4:0]       out_reg_dest,
  output logic [DBITS-1:0] out_wb_data,
  output logic [DBITS-1:0] out_pc,
  output logic             de_load_busy,
  output logic [4:0]       de_load_dest,
  output logic             err_misaligned,
  output logic             err_timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             hold_we_q, hold_we_d;
  logic             hold_wr_q, hold_wr_d;
  logic [4:0]       hold_dest_q, hold_dest_d;
  logic [DBITS-1:0] hold_addr_q, hold_addr_d;
  logic [DBITS-1:0] hold_data_q, hold_data_d;
  logic [DBITS-1:0] hold_pc_q, hold_pc_d;

  logic             out_valid_q, out_valid_d;
  logic             out_wr_q, out_wr_d;
  logic [4:0]       out_dest_q, out_dest_d;
  logic [DBITS-1:0] out_data_q, out_data_d;
  logic [DBITS-1:0] out_pc_q, out_pc_d;
  logic             err_mis_q, err_mis_d;
  logic             err_to_q, err_to_d;

  logic busy_s;
  assign busy_s = (state_q == BUSY);

  // Next-state, holding-register and writeback-latch decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_we_d   = hold_we_q;
    hold_wr_d   = hold_wr_q;
    hold_dest_d = hold_dest_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_pc_d   = hold_pc_q;
    out_valid_d = 1'b0;
    out_wr_d    = 1'b0;
    out_dest_d  = 5'd0;
    out_data_d  = {DBITS{1'b0}};
    out_pc_d    = {DBITS{1'b0}};
    err_mis_d   = 1'b0;
    err_to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_valid) begin
          state_d = IDLE;
        end else if (!(in_is_load || in_is_store)) begin
          out_valid_d = 1'b1;
          out_wr_d    = in_wr_reg && (in_reg_dest != 5'd0);
          out_dest_d  = in_reg_dest;
          out_data_d  = in_result;
          out_pc_d    = in_pc;
        end else if (in_mem_addr[1:0] != 2'b00) begin
          // Misaligned access retires immediately without touching memory.
          out_valid_d = 1'b1;
          out_dest_d  = in_reg_dest;
          out_data_d  = in_result;
          out_pc_d    = in_pc;
          err_mis_d   = 1'b1;
        end else begin
          state_d     = BUSY;
          cnt_d       = 8'd0;
          hold_we_d   = in_is_store;
          hold_wr_d   = in_wr_reg;
          hold_dest_d = in_reg_dest;
          hold_addr_d = in_mem_addr;
          hold_data_d = in_result;
          hold_pc_d   = in_pc;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_dest_d  = hold_dest_q;
          out_pc_d    = hold_pc_q;
          if (hold_we_q) begin
            out_wr_d   = 1'b0;
            out_data_d = hold_data_q;
          end else begin
            out_wr_d   = hold_wr_q && (hold_dest_q != 5'd0);
            out_data_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_dest_d  = hold_dest_q;
          out_pc_d    = hold_pc_q;
          err_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding and writeback registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      hold_we_q   <= 1'b0;
      hold_wr_q   <= 1'b0;
      hold_dest_q <= 5'd0;
      hold_addr_q <= {DBITS{1'b0}};
      hold_data_q <= {DBITS{1'b0}};
      hold_pc_q   <= {DBITS{1'b0}};
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      out_dest_q  <= 5'd0;
      out_data_q  <= {DBITS{1'b0}};
      out_pc_q    <= {DBITS{1'b0}};
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_we_q   <= hold_we_d;
      hold_wr_q   <= hold_wr_d;
      hold_dest_q <= hold_dest_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
      out_valid_q <= out_valid_d;
      out_wr_q    <= out_wr_d;
      out_dest_q  <= out_dest_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
      err_mis_q   <= err_mis_d;
      err_to_q    <= err_to_d;
    end
  end

  // Memory-side and hazard outputs derive only from registered state.
  assign in_ready       = ~busy_s;
  assign dmem_req       = busy_s;
  assign dmem_we        = busy_s & hold_we_q;
  assign dmem_addr      = busy_s ? {hold_addr_q[DBITS-1:2], 2'b00} : {DBITS{1'b0}};
  assign dmem_wdata     = busy_s ? hold_data_q : {DBITS{1'b0}};
  assign de_load_busy   = busy_s & ~hold_we_q;
  assign de_load_dest   = busy_s ? hold_dest_q : 5'd0;
  assign out_valid      = out_valid_q;
  assign out_wr_reg     = out_wr_q;
  assign out_reg_dest   = out_dest_q;
  assign out_wb_data    = out_data_q;
  assign out_pc         = out_pc_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a writeback scoreboard keyed by due cycle,
// checked every cycle, plus literal expectations after each scenario.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_is_load, in_is_store, in_wr_reg;
  logic [4:0]  in_reg_dest;
  logic [31:0] in_result, in_mem_addr, in_pc;
  logic        in_ready, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        out_valid, out_wr_reg;
  logic [4:0]  out_reg_dest;
  logic [31:0] out_wb_data, out_pc;
  logic        de_load_busy;
  logic [4:0]  de_load_dest;
  logic        err_misaligned, err_timeout;

  mem_stage #(.DBITS(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_wr_reg(in_wr_reg), .in_reg_dest(in_reg_dest), .in_result(in_result),
    .in_mem_addr(in_mem_addr), .in_pc(in_pc), .in_ready(in_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_wr_reg(out_wr_reg), .out_reg_dest(out_reg_dest),
    .out_wb_data(out_wb_data), .out_pc(out_pc), .de_load_busy(de_load_busy),
    .de_load_dest(de_load_dest), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        wr;
    logic [4:0]  dest;
    logic        chk_dest;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] pc;
    logic        emis;
    logic        eto;
  } wb_t;

  wb_t sb[$];
  wb_t e;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every cycle: either the scheduled writeback retires now, or the latch is empty.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("wb_valid", out_valid, 1'b1);
        chk("wb_wr", out_wr_reg, e.wr);
        chk("wb_pc", out_pc, e.pc);
        chk("wb_emis", err_misaligned, e.emis);
        chk("wb_eto", err_timeout, e.eto);
        if (e.chk_dest) chk("wb_dest", out_reg_dest, e.dest);
        if (e.chk_data) chk("wb_data", out_wb_data, e.data);
      end else begin
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_emis", err_misaligned, 1'b0);
        chk("idle_eto", err_timeout, 1'b0);
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("sb_stale", sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic wr,
                        input logic [31:0] pc);
    wb_t r;
    chk("alu_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_wr_reg = wr;
    in_reg_dest = rd; in_result = res; in_mem_addr = 32'h0; in_pc = pc;
    r = '{due: cyc + 1, wr: wr && (rd != 5'd0), dest: rd, chk_dest: 1'b1,
          data: res, chk_data: 1'b1, pc: pc, emis: 1'b0, eto: 1'b0};
    sb.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ack_at = busy cycle (1-based) in which ack is raised, 0 = never.
  // Returns at the negedge where the writeback latch holds the result.
  task automatic mem_op(input logic ld, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic [31:0] pc,
                        input int ack_at, input logic [31:0] rdata);
    wb_t r;
    int  c0, k;
    chk("mem_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_is_load = ld; in_is_store = !ld; in_wr_reg = ld;
    in_reg_dest = rd; in_result = data; in_mem_addr = addr; in_pc = pc;
    c0 = cyc;
    if (addr[1:0] != 2'b00) begin
      r = '{due: c0 + 1, wr: 1'b0, dest: rd, chk_dest: 1'b0, data: 32'h0,
            chk_data: 1'b0, pc: pc, emis: 1'b1, eto: 1'b0};
      sb.push_back(r);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mis_noreq", dmem_req, 1'b0);
      chk("mis_ready", in_ready, 1'b1);
      return;
    end
    k = (ack_at == 0 || ack_at > TO) ? TO : ack_at;
    r.due = c0 + k + 1; r.pc = pc; r.emis = 1'b0; r.eto = (k != ack_at);
    r.wr = !r.eto && ld && (rd != 5'd0);
    r.dest = rd; r.chk_dest = !r.eto && ld;
    r.data = ld ? rdata : data; r.chk_data = !r.eto;
    sb.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= k; i++) begin
      chk("busy_req", dmem_req, 1'b1);
      chk("busy_ready", in_ready, 1'b0);
      chk("busy_we", dmem_we, !ld);
      chk("busy_addr", dmem_addr, addr);
      if (!ld) chk("busy_wdata", dmem_wdata, data);
      chk("busy_ldbusy", de_load_busy, ld);
      if (ld) chk("busy_lddest", de_load_dest, rd);
      if (i == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
    end
    chk("done_req", dmem_req, 1'b0);
    chk("done_ready", in_ready, 1'b1);
    chk("done_ldbusy", de_load_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_wr_reg = 1'b0; in_reg_dest = 5'd0; in_result = 32'h0; in_mem_addr = 32'h0;
    in_pc = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #3;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_wb_data, 32'h0);
    chk("rst_ldbusy", de_load_busy, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    alu_op(32'h0000_0007, 5'd5, 1'b1, 32'h1000);
    alu_op(32'h0000_0007, 5'd5, 1'b1, 32'h1004);
    alu_op(32'h0000_0007, 5'd5, 1'b1, 32'h1008);
    chk("lit_add_data", out_wb_data, 32'h0000_0007);
    chk("lit_add_dest", out_reg_dest, 5'd5);
    chk("lit_add_pc", out_pc, 32'h1008);
    alu_op(32'h0000_0055, 5'd0, 1'b1, 32'h100C);
    chk("lit_rd0_wr", out_wr_reg, 1'b0);

    mem_op(1'b1, 32'h40, 32'h0, 5'd10, 32'h2000, 1, 32'hDEAD_BEEF);
    chk("lit_ld_valid", out_valid, 1'b1);
    chk("lit_ld_data", out_wb_data, 32'hDEAD_BEEF);
    chk("lit_ld_wr", out_wr_reg, 1'b1);

    mem_op(1'b0, 32'h80, 32'h1234, 5'd7, 32'h2004, 3, 32'hFFFF_FFFF);
    chk("lit_st_wr", out_wr_reg, 1'b0);
    chk("lit_st_data", out_wb_data, 32'h0000_1234);

    mem_op(1'b1, 32'h42, 32'h0, 5'd4, 32'h2008, 1, 32'h0);
    chk("lit_mis_err", err_misaligned, 1'b1);
    chk("lit_mis_wr", out_wr_reg, 1'b0);

    mem_op(1'b1, 32'h44, 32'h0, 5'd0, 32'h200C, 2, 32'hCAFE_F00D);
    chk("lit_ld0_wr", out_wr_reg, 1'b0);

    mem_op(1'b1, 32'h48, 32'h0, 5'd9, 32'h2010, 0, 32'h0);
    chk("lit_to_err", err_timeout, 1'b1);
    chk("lit_to_wr", out_wr_reg, 1'b0);

    mem_op(1'b1, 32'h4C, 32'h0, 5'd9, 32'h2014, TO, 32'h0BAD_F00D);
    chk("lit_ack4_err", err_timeout, 1'b0);
    chk("lit_ack4_data", out_wb_data, 32'h0BAD_F00D);

    alu_op(32'h0000_00AA, 5'd3, 1'b1, 32'h3000);

    // Reset while a load is outstanding: request must drop without a clock edge.
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_wr_reg = 1'b1;
    in_reg_dest = 5'd6; in_result = 32'h0; in_mem_addr = 32'h100; in_pc = 32'h4000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rb_req", dmem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ra_req", dmem_req, 1'b0);
    chk("ra_ready", in_ready, 1'b1);
    chk("ra_addr", dmem_addr, 32'h0);
    chk("ra_ldbusy", de_load_busy, 1'b0);
    chk("ra_lddest", de_load_dest, 5'd0);
    chk("ra_valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    alu_op(32'h0000_0011, 5'd8, 1'b1, 32'h5000);
    chk("lit_post_rst", out_wb_data, 32'h0000_0011);
    @(negedge clk); @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
